// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
// State codes, timeout counter width and the latched memory command layout.
package mem_port_arbiter_pkg;

   localparam int ARB_TIMEOUT_W = 8;

   // Fetches always go out as full-word accesses.
   localparam logic [2:0] MTYPE_WORD = 3'd0;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_IFETCH  = 2'd1,
      ARB_DACCESS = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  mtype;
   } mem_cmd_t;

   // Stores return zero on the data read-back path.
   function automatic logic [31:0] load_data(input logic we, input logic [31:0] rdata);
      return we ? 32'h0 : rdata;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// External memory port bundle: the arbiter is the master, the unified memory the slave.
interface mem_port_arbiter_if;

   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [2:0]  m_type;
   logic [31:0] m_rdata;
   logic        m_ack;

   modport master (
      output m_req, m_we, m_addr, m_wdata, m_type,
      input  m_rdata, m_ack
   );

   modport slave (
      input  m_req, m_we, m_addr, m_wdata, m_type,
      output m_rdata, m_ack
   );

endinterface

// File: rtl/arb_perf_counters.sv
// Wrapping 32-bit event counters for the arbiter; only exists when MEM_ARB_PERF_CNT_EN is defined.
`ifdef MEM_ARB_PERF_CNT_EN
module arb_perf_counters (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_if_valid,
   input  logic        i_d_valid,
   input  logic        i_stall,
   output logic [31:0] o_if_cnt,
   output logic [31:0] o_d_cnt,
   output logic [31:0] o_stall_cnt
);

   logic [31:0] r_if_cnt;
   logic [31:0] r_d_cnt;
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_if_cnt    <= 32'h0;
         r_d_cnt     <= 32'h0;
         r_stall_cnt <= 32'h0;
      end else begin
         if (i_if_valid) r_if_cnt    <= r_if_cnt + 32'd1;
         if (i_d_valid)  r_d_cnt     <= r_d_cnt + 32'd1;
         if (i_stall)    r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign o_if_cnt    = r_if_cnt;
   assign o_d_cnt     = r_d_cnt;
   assign o_stall_cnt = r_stall_cnt;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, data first with a fetch-starvation cap.
// Define MEM_ARB_PERF_CNT_EN to build the perf counters; otherwise perf_* outputs read zero.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_DBURST = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        i_if_req,
   input  logic [31:0] i_if_addr,
   input  logic        i_if_flush,
   output logic [31:0] o_if_rdata,
   output logic        o_if_valid,
   output logic        o_if_stall,

   input  logic        i_d_req,
   input  logic        i_d_we,
   input  logic [31:0] i_d_addr,
   input  logic [31:0] i_d_wdata,
   input  logic [2:0]  i_d_type,
   output logic [31:0] o_d_rdata,
   output logic        o_d_valid,
   output logic        o_d_stall,

   mem_port_arbiter_if.master mem,

   output logic        o_err_timeout,
   output logic [31:0] o_perf_if_cnt,
   output logic [31:0] o_perf_d_cnt,
   output logic [31:0] o_perf_stall_cnt
);

   localparam int                       DB_W      = $clog2(MAX_DBURST + 1);
   localparam logic [DB_W-1:0]          DB_MAX    = DB_W'(MAX_DBURST);
   localparam logic [ARB_TIMEOUT_W-1:0] WAIT_LAST = ARB_TIMEOUT_W'(TIMEOUT - 1);

   arb_state_t               r_state,    w_state_next;
   logic [DB_W-1:0]          r_dburst,   w_dburst_next;
   logic [ARB_TIMEOUT_W-1:0] r_wait,     w_wait_next;
   logic                     r_cancel,   w_cancel_next;
   mem_cmd_t                 r_cmd,      w_cmd_next;
   logic                     r_m_req,    w_m_req_next;
   logic                     r_if_valid, w_if_valid_next;
   logic [31:0]              r_if_rdata, w_if_rdata_next;
   logic                     r_d_valid,  w_d_valid_next;
   logic [31:0]              r_d_rdata,  w_d_rdata_next;
   logic                     r_err,      w_err_next;

   logic            w_force_if;
   logic            w_grant_d;
   logic            w_grant_if;
   logic            w_timeout;
   logic [DB_W-1:0] w_dburst_inc;

   // A fetch that has watched MAX_DBURST data grants go by wins the next slot.
   assign w_force_if   = i_if_req && (r_dburst == DB_MAX);
   assign w_grant_d    = i_d_req && !w_force_if;
   assign w_grant_if   = !w_grant_d && i_if_req;
   assign w_timeout    = (r_wait == WAIT_LAST);
   assign w_dburst_inc = (r_dburst == DB_MAX) ? DB_MAX : r_dburst + 1'b1;

   always_comb begin
      w_state_next    = r_state;
      w_dburst_next   = r_dburst;
      w_wait_next     = r_wait;
      w_cancel_next   = r_cancel;
      w_cmd_next      = r_cmd;
      w_m_req_next    = r_m_req;
      w_if_valid_next = 1'b0;
      w_if_rdata_next = r_if_rdata;
      w_d_valid_next  = 1'b0;
      w_d_rdata_next  = r_d_rdata;
      w_err_next      = r_err;

      case (r_state)
         ARB_IDLE: begin
            w_wait_next   = '0;
            w_cancel_next = 1'b0;
            if (w_grant_d) begin
               w_state_next  = ARB_DACCESS;
               w_m_req_next  = 1'b1;
               w_cmd_next    = '{we: i_d_we, addr: i_d_addr, wdata: i_d_wdata, mtype: i_d_type};
               w_dburst_next = i_if_req ? w_dburst_inc : '0;
            end else if (w_grant_if) begin
               w_state_next  = ARB_IFETCH;
               w_m_req_next  = 1'b1;
               w_cmd_next    = '{we: 1'b0, addr: i_if_addr, wdata: 32'h0, mtype: MTYPE_WORD};
               w_dburst_next = '0;
            end else begin
               w_dburst_next = '0;
            end
         end

         ARB_IFETCH: begin
            // Memory cannot abort, so a redirect only hides the result when it lands.
            if (i_if_flush) w_cancel_next = 1'b1;
            if (mem.m_ack) begin
               w_state_next    = ARB_IDLE;
               w_m_req_next    = 1'b0;
               w_if_valid_next = !(r_cancel || i_if_flush);
               w_if_rdata_next = mem.m_rdata;
            end else if (w_timeout) begin
               w_state_next    = ARB_IDLE;
               w_m_req_next    = 1'b0;
               w_if_valid_next = !(r_cancel || i_if_flush);
               w_if_rdata_next = 32'h0;
               w_err_next      = 1'b1;
            end else begin
               w_wait_next = r_wait + 1'b1;
            end
         end

         ARB_DACCESS: begin
            if (mem.m_ack) begin
               w_state_next   = ARB_IDLE;
               w_m_req_next   = 1'b0;
               w_d_valid_next = 1'b1;
               w_d_rdata_next = load_data(r_cmd.we, mem.m_rdata);
            end else if (w_timeout) begin
               w_state_next   = ARB_IDLE;
               w_m_req_next   = 1'b0;
               w_d_valid_next = 1'b1;
               w_d_rdata_next = 32'h0;
               w_err_next     = 1'b1;
            end else begin
               w_wait_next = r_wait + 1'b1;
            end
         end

         default: begin
            w_state_next = ARB_IDLE;
            w_m_req_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ARB_IDLE;
         r_dburst   <= '0;
         r_wait     <= '0;
         r_cancel   <= 1'b0;
         r_cmd      <= '0;
         r_m_req    <= 1'b0;
         r_if_valid <= 1'b0;
         r_if_rdata <= 32'h0;
         r_d_valid  <= 1'b0;
         r_d_rdata  <= 32'h0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_dburst   <= w_dburst_next;
         r_wait     <= w_wait_next;
         r_cancel   <= w_cancel_next;
         r_cmd      <= w_cmd_next;
         r_m_req    <= w_m_req_next;
         r_if_valid <= w_if_valid_next;
         r_if_rdata <= w_if_rdata_next;
         r_d_valid  <= w_d_valid_next;
         r_d_rdata  <= w_d_rdata_next;
         r_err      <= w_err_next;
      end
   end

   assign mem.m_req   = r_m_req;
   assign mem.m_we    = r_cmd.we;
   assign mem.m_addr  = r_cmd.addr;
   assign mem.m_wdata = r_cmd.wdata;
   assign mem.m_type  = r_cmd.mtype;

   assign o_if_rdata    = r_if_rdata;
   assign o_if_valid    = r_if_valid;
   assign o_if_stall    = i_if_req & ~r_if_valid;
   assign o_d_rdata     = r_d_rdata;
   assign o_d_valid     = r_d_valid;
   assign o_d_stall     = i_d_req & ~r_d_valid;
   assign o_err_timeout = r_err;

`ifdef MEM_ARB_PERF_CNT_EN
   arb_perf_counters u_perf (
      .clk         (clk),
      .rst         (rst),
      .i_if_valid  (r_if_valid),
      .i_d_valid   (r_d_valid),
      .i_stall     (o_if_stall | o_d_stall),
      .o_if_cnt    (o_perf_if_cnt),
      .o_d_cnt     (o_perf_d_cnt),
      .o_stall_cnt (o_perf_stall_cnt)
   );
`else
   assign o_perf_if_cnt    = 32'h0;
   assign o_perf_d_cnt     = 32'h0;
   assign o_perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory answers m_req, queues hold expected grants and results.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_flush, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [2:0]  d_type;
   logic [31:0] if_rdata, d_rdata, perf_if, perf_d, perf_st;
   logic        if_valid, if_stall, d_valid, d_stall, err_timeout;

   mem_port_arbiter_if bus ();

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
      .o_if_rdata(if_rdata), .o_if_valid(if_valid), .o_if_stall(if_stall),
      .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_type(d_type),
      .o_d_rdata(d_rdata), .o_d_valid(d_valid), .o_d_stall(d_stall),
      .mem(bus),
      .o_err_timeout(err_timeout),
      .o_perf_if_cnt(perf_if), .o_perf_d_cnt(perf_d), .o_perf_stall_cnt(perf_st)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_type;
      logic [2:0]  mtype;
   } grant_t;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] if_q[$];
   logic [31:0] d_q[$];
   grant_t      g_q[$];
   int          ack_delay = 0;
   int          busy_cyc = 0;
   bit          late_ack = 1'b0;
   bit          seen_if, seen_d;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a ^ 32'hA5C3_5A3C;
   endfunction

   // One clock: compare valid pulses against the scoreboard, then play the memory side.
   task automatic step();
      logic [31:0] exp_v;
      grant_t      g;
      @(posedge clk);
      #1;
      seen_if = if_valid;
      seen_d  = d_valid;
      if (if_valid) begin
         checks++;
         if (if_q.size() == 0) begin
            errors++;
            $display("FAIL if_valid_unexpected: got pulse with if_rdata=%h, required no pulse", if_rdata);
         end else begin
            exp_v = if_q.pop_front();
            if (if_rdata !== exp_v) begin
               errors++;
               $display("FAIL if_rdata: got %h, required %h", if_rdata, exp_v);
            end else $display("if_valid  rdata=%h ok", if_rdata);
         end
      end
      if (d_valid) begin
         checks++;
         if (d_q.size() == 0) begin
            errors++;
            $display("FAIL d_valid_unexpected: got pulse with d_rdata=%h, required no pulse", d_rdata);
         end else begin
            exp_v = d_q.pop_front();
            if (d_rdata !== exp_v) begin
               errors++;
               $display("FAIL d_rdata: got %h, required %h", d_rdata, exp_v);
            end else $display("d_valid   rdata=%h ok", d_rdata);
         end
      end
      if (bus.m_req === 1'b1) begin
         if (busy_cyc == 0) begin
            checks++;
            if (g_q.size() == 0) begin
               errors++;
               $display("FAIL grant_unexpected: got m_addr=%h m_we=%b, required no grant", bus.m_addr, bus.m_we);
            end else begin
               g = g_q.pop_front();
               if (bus.m_addr !== g.addr || bus.m_we !== g.we || (g.we && bus.m_wdata !== g.wdata) ||
                   (g.chk_type && bus.m_type !== g.mtype)) begin
                  errors++;
                  $display("FAIL grant: got addr=%h we=%b wdata=%h type=%0d, required addr=%h we=%b wdata=%h type=%0d",
                           bus.m_addr, bus.m_we, bus.m_wdata, bus.m_type, g.addr, g.we, g.wdata, g.mtype);
               end else $display("grant     addr=%h we=%b ok", bus.m_addr, bus.m_we);
            end
         end
         bus.m_ack   = (ack_delay >= 0) && (busy_cyc == ack_delay);
         bus.m_rdata = bus.m_ack ? mem_data(bus.m_addr) : 32'hBAD0_BAD0;
         busy_cyc++;
      end else begin
         busy_cyc    = 0;
         bus.m_ack   = late_ack;
         bus.m_rdata = 32'hBAD0_BAD0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; if_req = 1'b1; if_flush = 1'b0; if_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_type = 3'd0;
      bus.m_ack = 1'b0; bus.m_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_type} !== 69'h0) begin
         errors++; $display("FAIL reset_mem_bus: got req=%b addr=%h, required all zero", bus.m_req, bus.m_addr);
      end
      checks++;
      if ({if_valid, d_valid, if_rdata, d_rdata, err_timeout} !== 67'h0) begin
         errors++; $display("FAIL reset_outputs: got if_valid=%b d_valid=%b err=%b, required all zero", if_valid, d_valid, err_timeout);
      end
      checks++;
      if (if_stall !== 1'b1 || d_stall !== 1'b0) begin
         errors++; $display("FAIL reset_stalls: got if_stall=%b d_stall=%b, required 1 0", if_stall, d_stall);
      end
      checks++;
      if ({perf_if, perf_d, perf_st} !== 96'h0) begin
         errors++; $display("FAIL reset_perf: got %h %h %h, required zero", perf_if, perf_d, perf_st);
      end
      $display("reset     checked");
      if_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_fetch();
      logic [31:0] e_if, e_d, e_st;
      ack_delay = 0;
      if_req = 1'b1; if_addr = 32'h0000_0040;
      if_q.push_back(mem_data(32'h40));
      g_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0, chk_type: 1'b0, mtype: 3'd0});
      #1;
      checks++;
      if (if_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_c0: got %b, required 1", if_stall); end
      step();
      checks++;
      if (bus.m_req !== 1'b1 || if_stall !== 1'b1 || if_valid !== 1'b0) begin
         errors++; $display("FAIL fetch_c1: got m_req=%b if_stall=%b if_valid=%b, required 1 1 0", bus.m_req, if_stall, if_valid);
      end
      step();
      checks++;
      if (seen_if !== 1'b1 || bus.m_req !== 1'b0 || if_stall !== 1'b0) begin
         errors++; $display("FAIL fetch_c2: got if_valid=%b m_req=%b if_stall=%b, required 1 0 0", seen_if, bus.m_req, if_stall);
      end
      if_req = 1'b0;
      step();
`ifdef MEM_ARB_PERF_CNT_EN
      e_if = 32'd1; e_d = 32'd0; e_st = 32'd2;
`else
      e_if = 32'd0; e_d = 32'd0; e_st = 32'd0;
`endif
      checks++;
      if (perf_if !== e_if || perf_d !== e_d || perf_st !== e_st) begin
         errors++; $display("FAIL perf_after_fetch: got if=%0d d=%0d stall=%0d, required %0d %0d %0d",
                            perf_if, perf_d, perf_st, e_if, e_d, e_st);
      end
   endtask

   task automatic test_data_priority();
      int d_at = -1;
      int if_at = -1;
      if_req = 1'b1; if_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234_5678; d_type = 3'd2;
      g_q.push_back('{we: 1'b1, addr: 32'h100, wdata: 32'h1234_5678, chk_type: 1'b1, mtype: 3'd2});
      g_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0, chk_type: 1'b0, mtype: 3'd0});
      d_q.push_back(32'h0);
      if_q.push_back(mem_data(32'h40));
      for (int i = 0; i < 20 && if_at < 0; i++) begin
         step();
         if (seen_d) begin d_at = i; d_req = 1'b0; d_we = 1'b0; end
         if (seen_if) begin if_at = i; if_req = 1'b0; end
      end
      checks++;
      if (d_at != 1 || if_at != 3) begin
         errors++; $display("FAIL data_priority_timing: got d_valid@%0d if_valid@%0d, required 1 and 3", d_at, if_at);
      end
   endtask

   task automatic test_dburst();
      int n_d = 0;
      int n_d_at_if = -1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_type = 3'd2;
      if_req = 1'b1; if_addr = 32'h40;
      for (int k = 0; k < 4; k++) begin
         d_q.push_back(mem_data(32'h100));
         g_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, chk_type: 1'b1, mtype: 3'd2});
      end
      g_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0, chk_type: 1'b0, mtype: 3'd0});
      if_q.push_back(mem_data(32'h40));
      for (int i = 0; i < 40 && n_d_at_if < 0; i++) begin
         step();
         if (seen_d) n_d++;
         if (seen_if) begin n_d_at_if = n_d; if_req = 1'b0; d_req = 1'b0; end
      end
      repeat (4) step();
      checks++;
      if (n_d_at_if != 4) begin
         errors++; $display("FAIL dburst_count: got %0d data grants before fetch, required 4", n_d_at_if);
      end
      checks++;
      if (g_q.size() != 0 || d_q.size() != 0 || if_q.size() != 0) begin
         errors++; $display("FAIL dburst_drain: got %0d/%0d/%0d pending, required 0", g_q.size(), d_q.size(), if_q.size());
      end
   endtask

   task automatic test_flush_cancel();
      bit done = 1'b0;
      ack_delay = 3;
      if_req = 1'b1; if_addr = 32'h200;
      g_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0, chk_type: 1'b0, mtype: 3'd0});
      step();
      checks++;
      if (bus.m_req !== 1'b1) begin errors++; $display("FAIL flush_busy: got m_req=%b, required 1", bus.m_req); end
      if_flush = 1'b1; if_addr = 32'h300;
      g_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0, chk_type: 1'b0, mtype: 3'd0});
      if_q.push_back(mem_data(32'h300));
      step();
      if_flush = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         step();
         if (seen_if) begin done = 1'b1; if_req = 1'b0; end
      end
      step();
      checks++;
      if (!done || g_q.size() != 0 || if_q.size() != 0) begin
         errors++; $display("FAIL flush_refetch: got done=%b pending grants=%0d results=%0d, required 1 0 0", done, g_q.size(), if_q.size());
      end
      ack_delay = 0;
   endtask

   task automatic test_timeout();
      int busy = 0;
      bit done = 1'b0;
      ack_delay = -1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h180; d_type = 3'd2;
      g_q.push_back('{we: 1'b0, addr: 32'h180, wdata: 32'h0, chk_type: 1'b1, mtype: 3'd2});
      d_q.push_back(32'h0);
      for (int i = 0; i < 300 && !done; i++) begin
         step();
         if (bus.m_req === 1'b1) busy++;
         else if (busy > 0) begin
            done = 1'b1;
            d_req = 1'b0;
            checks++;
            if (busy != 255 || seen_d !== 1'b1 || err_timeout !== 1'b1) begin
               errors++; $display("FAIL timeout: got busy=%0d d_valid=%b err=%b, required 255 1 1", busy, seen_d, err_timeout);
            end
         end
      end
      checks++;
      if (!done) begin errors++; $display("FAIL timeout_wait: got no release after %0d busy cycles, required release", busy); end
      ack_delay = 0;
      late_ack = 1'b1;
      step();
      late_ack = 1'b0;
      step();
      step();
      checks++;
      if (err_timeout !== 1'b1 || bus.m_req !== 1'b0) begin
         errors++; $display("FAIL timeout_sticky: got err=%b m_req=%b, required 1 0", err_timeout, bus.m_req);
      end
   endtask

   task automatic test_async_reset();
      ack_delay = 3;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1C0; d_wdata = 32'hCAFE_F00D; d_type = 3'd1;
      g_q.push_back('{we: 1'b1, addr: 32'h1C0, wdata: 32'hCAFE_F00D, chk_type: 1'b1, mtype: 3'd1});
      step();
      checks++;
      if (bus.m_req !== 1'b1) begin errors++; $display("FAIL areset_busy: got m_req=%b, required 1", bus.m_req); end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.m_req !== 1'b0 || dut.r_state !== 2'd0 || err_timeout !== 1'b0 || d_valid !== 1'b0) begin
         errors++; $display("FAIL areset_clear: got m_req=%b state=%0d err=%b d_valid=%b, required 0 0 0 0",
                            bus.m_req, dut.r_state, err_timeout, d_valid);
      end
      checks++;
      if ({perf_if, perf_d, perf_st} !== 96'h0) begin
         errors++; $display("FAIL areset_perf: got %h %h %h, required zero", perf_if, perf_d, perf_st);
      end
      d_req = 1'b0; d_we = 1'b0;
      ack_delay = 0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) step();
      checks++;
      if (bus.m_req !== 1'b0 || g_q.size() != 0 || d_q.size() != 0) begin
         errors++; $display("FAIL areset_idle: got m_req=%b pending=%0d/%0d, required 0 0 0", bus.m_req, g_q.size(), d_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_data_priority();
      test_dburst();
      test_flush_cancel();
      test_timeout();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000 time units, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
